// File: rtl/systolic1x4_drain.sv
// Result drain for the 1x4 systolic array: snapshots c0..c3 with de-skew
// (c_i sampled i cycles after the capture request), then serializes the four
// results as beats idx 0..3 on a valid/ready stream.
//
// Latency: a capture pulse sampled at edge E0 raises out_valid after E3; the
// earliest first transfer is at E4. With out_ready held high, the four beats
// transfer at E4..E7. busy and out_valid fall after E7.
//
// Backpressure: out_ready=0 stalls indefinitely. out_data/out_idx/out_last
// are held until the beat is accepted. A cap arriving while busy is dropped
// and sets the sticky overrun flag. The exception is a cap on the final-transfer
// edge, which starts the next snapshot immediately.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   cap                capture request pulse
//   clr_ovr            synchronous clear of overrun (a simultaneous drop wins)
//   c0..c3             array accumulator outputs (W bits each)
//   out_data/out_idx   current beat and the PE index it came from
//   out_last           high with the idx-3 beat only
//   out_valid/out_ready  stream handshake
//   busy               high while capturing or sending
//   overrun            sticky flag: a cap was dropped
module systolic1x4_drain #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cap,
    input  logic         clr_ovr,
    input  logic [W-1:0] c0,
    input  logic [W-1:0] c1,
    input  logic [W-1:0] c2,
    input  logic [W-1:0] c3,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_idx,
    output logic         out_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t       state;
    logic [W-1:0] snap0;
    logic [W-1:0] snap1;
    logic [W-1:0] snap2;
    logic [W-1:0] snap3;
    logic [1:0]   cc;

    logic xfer;
    logic final_xfer;
    logic cap_take;
    logic cap_drop;

    // out_valid is only ever high in SEND, so xfer implies SEND.
    assign xfer       = out_valid & out_ready;
    assign final_xfer = xfer & (out_idx == 2'd3);
    // A cap is honoured in IDLE, or on the edge that retires the last beat
    // (back-to-back snapshots). Anywhere else it is dropped.
    assign cap_take   = cap & ((state == IDLE) | final_xfer);
    assign cap_drop   = cap & ~cap_take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            snap0     <= '0;
            snap1     <= '0;
            snap2     <= '0;
            snap3     <= '0;
            cc        <= 2'd0;
            out_idx   <= 2'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // A dropped cap takes priority over a clear on the same edge.
            if (cap_drop) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cap_take) begin
                        snap0 <= c0;
                        cc    <= 2'd1;
                        busy  <= 1'b1;
                        state <= CAPT;
                    end
                end

                CAPT: begin
                    // PE cc lags PE 0 by cc cycles, so its result is valid now.
                    case (cc)
                        2'd1:    snap1 <= c1;
                        2'd2:    snap2 <= c2;
                        2'd3:    snap3 <= c3;
                        default: ;
                    endcase
                    cc <= cc + 2'd1;
                    if (cc == 2'd3) begin
                        state     <= SEND;
                        out_idx   <= 2'd0;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                    end
                end

                SEND: begin
                    if (xfer) begin
                        // Wraps 3 -> 0 on the final beat, leaving idx ready
                        // for the next burst.
                        out_idx  <= out_idx + 2'd1;
                        out_last <= (out_idx == 2'd2);
                        if (out_idx == 2'd3) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            if (cap_take) begin
                                snap0 <= c0;
                                cc    <= 2'd1;
                                state <= CAPT;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Beat data is a pure mux of registers, so it cannot change while a
    // stalled beat waits for out_ready.
    always_comb begin
        out_data = snap0;
        case (out_idx)
            2'd0: out_data = snap0;
            2'd1: out_data = snap1;
            2'd2: out_data = snap2;
            2'd3: out_data = snap3;
            default: out_data = snap0;
        endcase
    end

endmodule

// File: tb/tb_systolic1x4_drain.sv
module tb_systolic1x4_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        cap;
    logic        clr_ovr;
    logic        out_ready;
    logic [31:0] c0, c1, c2, c3;
    logic [31:0] out_data;
    logic [1:0]  out_idx;
    logic        out_last;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    always #5 clk = ~clk;

    systolic1x4_drain #(.W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .cap       (cap),
        .clr_ovr   (clr_ovr),
        .c0        (c0),
        .c1        (c1),
        .c2        (c2),
        .c3        (c3),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overrun   (overrun)
    );

    localparam logic [31:0] J = 32'h0000_DEAD;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a snapshot is the vector {c_k sampled k edges after
    // the accepted cap}; it is then played out as 4 beats, one per accepted
    // handshake.
    logic [31:0] m_snap [4];
    int          m_capt;     // edge number of accepted cap, -1 when none pending
    bit          m_send;
    int          m_idx;
    bit          m_ovr;
    int          en;

    // Observed transfers: {last, idx, data}
    logic [34:0] beats [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_snap[i] = 32'd0;
        m_capt = -1;
        m_send = 1'b0;
        m_idx  = 0;
        m_ovr  = 1'b0;
        en     = 0;
    endtask

    task automatic check_all();
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_send});
        chk("out_idx",   {30'd0, out_idx},   m_idx);
        chk("out_last",  {31'd0, out_last},  {31'd0, (m_send && m_idx == 3)});
        chk("busy",      {31'd0, busy},      {31'd0, (m_capt >= 0 || m_send)});
        chk("overrun",   {31'd0, overrun},   {31'd0, m_ovr});
        chk("out_data",  out_data,           m_snap[m_idx]);
    endtask

    task automatic check_zero();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_idx",   {30'd0, out_idx},   32'd0);
        chk("rst_out_last",  {31'd0, out_last},  32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_overrun",   {31'd0, overrun},   32'd0);
        chk("rst_out_data",  out_data,           32'd0);
    endtask

    // One clock: drive inputs, record any handshake, advance the model at the
    // edge, check all outputs 1 time unit after the edge.
    task automatic step(input logic cp, input logic cl, input logic rd,
                        input logic [31:0] v0, input logic [31:0] v1,
                        input logic [31:0] v2, input logic [31:0] v3);
        logic [31:0] cv [4];
        bit was_busy, xf, fin;
        int k;
        cap = cp; clr_ovr = cl; out_ready = rd;
        c0 = v0; c1 = v1; c2 = v2; c3 = v3;
        cv[0] = v0; cv[1] = v1; cv[2] = v2; cv[3] = v3;
        if (out_valid && out_ready) beats.push_back({out_last, out_idx, out_data});
        @(posedge clk);
        was_busy = (m_capt >= 0) || m_send;
        xf  = m_send && rd;
        fin = xf && (m_idx == 3);
        en++;
        if (m_capt >= 0) begin
            k = en - m_capt;
            m_snap[k] = cv[k];
            if (k == 3) begin
                m_capt = -1;
                m_send = 1'b1;
                m_idx  = 0;
            end
        end
        if (xf) begin
            m_idx = (m_idx + 1) % 4;
            if (fin) m_send = 1'b0;
        end
        if (cp && (!was_busy || fin)) begin
            m_capt    = en;
            m_snap[0] = cv[0];
        end
        if (cp && !(!was_busy || fin)) m_ovr = 1'b1;
        else if (cl)                   m_ovr = 1'b0;
        #1;
        check_all();
    endtask

    task automatic rstep(input logic cp, input logic cl, input logic rd);
        step(cp, cl, rd, $urandom, $urandom, $urandom, $urandom);
    endtask

    // Four-edge capture with junk on the PE ports that must not be sampled.
    task automatic capture(input logic [31:0] v [4], input logic rd);
        step(1'b1, 1'b0, rd, v[0], J, J, J);
        step(1'b0, 1'b0, rd, J, v[1], J, J);
        step(1'b0, 1'b0, rd, J, J, v[2], J);
        step(1'b0, 1'b0, rd, J, J, J, v[3]);
    endtask

    task automatic check_burst(input string tag, input int off, input logic [31:0] v [4]);
        for (int i = 0; i < 4; i++) begin
            if (off + i < beats.size()) begin
                chk({tag, "_data"}, beats[off+i][31:0], v[i]);
                chk({tag, "_idx"},  {30'd0, beats[off+i][33:32]}, i);
                chk({tag, "_last"}, {31'd0, beats[off+i][34]}, {31'd0, (i == 3)});
            end else begin
                chk({tag, "_missing"}, off + i, beats.size());
            end
        end
    endtask

    initial begin
        logic [31:0] va [4];
        logic [31:0] vb [4];

        // Reset then idle
        rst = 1'b1; cap = 1'b0; clr_ovr = 1'b0; out_ready = 1'b0;
        c0 = J; c1 = J; c2 = J; c3 = J;
        model_reset();
        #2;
        check_zero();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) rstep(1'b0, 1'b0, 1'($urandom_range(0, 1)));

        // De-skew capture with out_ready held high
        va[0] = 32'd525; va[1] = 32'd75; va[2] = 32'd25; va[3] = 32'd7;
        beats.delete();
        capture(va, 1'b1);
        chk("deskew_valid_after_E3", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 4; i++) rstep(1'b0, 1'b0, 1'b1);
        chk("deskew_idle_after_E7", {31'd0, busy}, 32'd0);
        rstep(1'b0, 1'b0, 1'b1);
        chk("deskew_count", beats.size(), 4);
        check_burst("deskew", 0, va);

        // Backpressure: 5 stalled cycles, then 1/0 toggling
        beats.delete();
        capture(va, 1'b0);
        for (int i = 0; i < 5; i++) rstep(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) rstep(1'b0, 1'b0, 1'(i % 2 == 0));
        chk("bp_count", beats.size(), 4);
        check_burst("bp", 0, va);

        // Overrun: second cap at E2 is dropped
        beats.delete();
        for (int i = 0; i < 4; i++) va[i] = $urandom;
        step(1'b1, 1'b0, 1'b1, va[0], J, J, J);
        step(1'b0, 1'b0, 1'b1, J, va[1], J, J);
        step(1'b1, 1'b0, 1'b1, J, J, va[2], J);
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        step(1'b0, 1'b0, 1'b1, J, J, J, va[3]);
        for (int i = 0; i < 6; i++) rstep(1'b0, 1'b0, 1'b1);
        chk("ovr_count", beats.size(), 4);
        check_burst("ovr", 0, va);
        rstep(1'b0, 1'b1, 1'b1);
        chk("ovr_clr", {31'd0, overrun}, 32'd0);
        rstep(1'b1, 1'b0, 1'b1);
        rstep(1'b1, 1'b1, 1'b1);
        chk("ovr_drop_beats_clr", {31'd0, overrun}, 32'd1);
        for (int i = 0; i < 7; i++) rstep(1'b0, 1'b0, 1'b1);
        rstep(1'b0, 1'b1, 1'b1);

        // Back-to-back: cap on the idx-3 transfer edge
        beats.delete();
        for (int i = 0; i < 4; i++) begin va[i] = $urandom; vb[i] = $urandom; end
        capture(va, 1'b1);
        for (int i = 0; i < 3; i++) rstep(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, vb[0], J, J, J);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        step(1'b0, 1'b0, 1'b1, J, vb[1], J, J);
        step(1'b0, 1'b0, 1'b1, J, J, vb[2], J);
        step(1'b0, 1'b0, 1'b1, J, J, J, vb[3]);
        chk("b2b_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) rstep(1'b0, 1'b0, 1'b1);
        chk("b2b_count", beats.size(), 8);
        chk("b2b_ovr", {31'd0, overrun}, 32'd0);
        check_burst("b2b_first", 0, va);
        check_burst("b2b_second", 4, vb);

        // Reset mid-SEND after beat 1 is accepted
        for (int i = 0; i < 4; i++) va[i] = $urandom;
        capture(va, 1'b1);
        rstep(1'b0, 1'b0, 1'b1);
        rstep(1'b0, 1'b0, 1'b1);
        rstep(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        check_zero();
        @(posedge clk); #1;
        rst = 1'b0;
        beats.delete();
        rstep(1'b0, 1'b0, 1'b1);
        chk("rst_no_beat", beats.size(), 0);
        for (int i = 0; i < 4; i++) va[i] = $urandom;
        capture(va, 1'b1);
        for (int i = 0; i < 5; i++) rstep(1'b0, 1'b0, 1'b1);
        chk("rst_count", beats.size(), 4);
        check_burst("rst_burst", 0, va);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++)
            rstep(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 9) < 7));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
